tdc_seq_ctrl: RTL and testbench
===============================

TDC_SEQ_CTRL -- requirements
Module: tdc_seq_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, hit buffer entries (1 start + up to 3 stops).
REQ-002 SHALL have parameter OUT_WAIT_MAX, default 8, cycles allowed between end of a calc burst and tof_cal out_valid.
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: arm  in  1  pulse, start new measurement; stop_num  in  2  expected stops (1..3, 0 treated as 1); range  in  15  range limit, also drives tof_cal.
REQ-005 SHALL have ports: hit_valid  in  1  front-end event strobe; hit_code  in  32  thermometer code; hit_coarse  in  10  coarse counter at event.
REQ-006 SHALL have ports: cal_en  out  1; cal_code  out  32; cal_cnt  out  3; cal_counter  out  10 (these drive tof_cal cal_en/decode_in/cnt/counter_in).
REQ-007 SHALL have ports: tof_valid  in  1  tof_cal out_valid; tof_data  in  15  tof_cal tof_data_in.
REQ-008 SHALL have ports: res_valid  out  1; res_data  out  15; res_idx  out  2 (stop number 1..3); meas_done  out  1 pulse; busy  out  1; err  out  2 ({timeout, overflow}).

Function
REQ-009 SHALL implement FSM IDLE, ARMED, LOAD, CALC, WAIT_OUT, DONE; busy=1 in every state except IDLE.
REQ-010 IDLE: arm -> ARMED, clears FIFO, hit counter, err; hit_valid in IDLE ignored.
REQ-011 ARMED/LOAD/CALC/WAIT_OUT: each hit_valid pushes {hit_code, hit_coarse} until stop_num+1 hits accepted; further hits dropped.
REQ-012 Push with FIFO full SHALL drop the hit and set err[0] (sticky until next arm).
REQ-013 ARMED -> LOAD when FIFO non-empty; LOAD pops head onto cal_code/cal_counter and sets cal_cnt = hit ordinal (1 = start, 2..4 = stops), one cycle.
REQ-014 CALC SHALL assert cal_en for exactly 5 consecutive cycles with cal_code, cal_cnt, cal_counter held stable, then enter WAIT_OUT.
REQ-015 WAIT_OUT: tof_valid with cal_cnt=1 (start) -> no result; with cal_cnt 2..4 -> res_valid pulse 1 cycle, res_data=tof_data, res_idx=cal_cnt-1.
REQ-016 After tof_valid: if ordinal == stop_num+1 -> DONE; else FIFO non-empty -> LOAD; else -> ARMED.
REQ-017 No tof_valid within OUT_WAIT_MAX cycles -> res_valid with res_data=15'h7FFF for stops, then continue per REQ-016.
REQ-018 DONE: meas_done pulses 1 cycle, -> IDLE next cycle.
REQ-019 arm while busy SHALL be ignored.
REQ-020 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-021 Hit ordinal counter 3-bit, saturates at stop_num+1; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-022 rst SHALL, at clk edge, force IDLE, empty FIFO, and zero cal_en, cal_code, cal_cnt, cal_counter, res_valid, res_data, res_idx, meas_done, busy, err.
REQ-023 rst mid-CALC SHALL deassert cal_en next edge; no res_valid or meas_done for the aborted measurement.

Configuration
REQ-024 Macro TDC_SEQ_TIMEOUT_EN defined: 10-bit watchdog counts cycles from entering ARMED; reaching range[14:5] before all stop_num+1 hits accepted sets err[1], emits res_valid 15'h7FFF for each missing stop in order, then DONE.
REQ-025 Macro undefined: no watchdog, err[1] tied 0, controller waits in ARMED indefinitely.

Structure
REQ-026 Shared package tdc_pkg SHALL hold FSM state enum, TOF_INVALID=15'h7FFF, CAL_BURST=5, hit entry struct {code[31:0], coarse[9:0]}.
REQ-027 Hit buffer SHALL be sub-module tdc_hit_fifo (sync FIFO, full/empty, parameterised depth/width); FSM and timers in tdc_seq_ctrl.

Verification
REQ-028 arm, stop_num=1, hits code 0x0000FFFF/coarse 5 then 0x000FFFFF/coarse 9, model tof_valid 2 cycles after each burst, tof_data 0x0124 -> exactly two 5-cycle cal_en bursts, cal_cnt 1 then 2, one res_valid res_idx=1 data 0x0124, meas_done.
REQ-029 stop_num=3, four back-to-back hits -> four bursts, cal_cnt 1,2,3,4, res_idx 1,2,3, err=0.
REQ-030 stop_num=1, five hits with tof_valid withheld -> err[0]=1, only 2 bursts.
REQ-031 tof_valid never returns for a stop -> after 8 cycles res_data=0x7FFF, FSM continues.
REQ-032 TDC_SEQ_TIMEOUT_EN, range=15'h0040, stop_num=2, only start hit -> err[1]=1 after 2 watchdog cycles, res_idx 1 and 2 with 0x7FFF, meas_done.
REQ-033 rst on 3rd cal_en cycle -> cal_en=0 next cycle, busy=0, no meas_done.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and constants for the TDC measurement sequencer.
package tdc_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, LOAD, CALC, WAIT_OUT, DONE} state_t;
  localparam logic [14:0] TOF_INVALID = 15'h7FFF;
  localparam int CAL_BURST = 5;
  typedef struct packed {
    logic [31:0] code;
    logic [9:0]  coarse;
  } hit_t;
endpackage

// File: rtl/tdc_hit_fifo.sv
// tdc_hit_fifo: synchronous hit buffer with full/empty and same-cycle push+pop.
module tdc_hit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign dout    = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst || clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
      if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/tdc_seq_ctrl.sv
// tdc_seq_ctrl: sequences start/stop hits through tof_cal and collects results.
// Optional watchdog: define TDC_SEQ_TIMEOUT_EN.
module tdc_seq_ctrl
  import tdc_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int OUT_WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [1:0]  stop_num,
  input  logic [14:0] range,
  input  logic        hit_valid,
  input  logic [31:0] hit_code,
  input  logic [9:0]  hit_coarse,
  output logic        cal_en,
  output logic [31:0] cal_code,
  output logic [2:0]  cal_cnt,
  output logic [9:0]  cal_counter,
  input  logic        tof_valid,
  input  logic [14:0] tof_data,
  output logic        res_valid,
  output logic [14:0] res_data,
  output logic [1:0]  res_idx,
  output logic        meas_done,
  output logic        busy,
  output logic [1:0]  err
);
  localparam int WW = $clog2(OUT_WAIT_MAX + 1);
  state_t state, nxt;
  hit_t wr_hit, rd_hit;
  logic [2:0] need, hit_cnt, bcnt, ord;
  logic [WW-1:0] wcnt;
  logic coll, full, empty, push, pop, drop, fin, emit, tmo;

  assign coll      = state inside {ARMED, LOAD, CALC, WAIT_OUT};
  assign wr_hit    = '{code: hit_code, coarse: hit_coarse};
  assign push      = coll && hit_valid && hit_cnt < need && !tmo && (!full || pop);
  assign drop      = coll && hit_valid && !push;
  assign pop       = state == LOAD;
  assign fin       = state == WAIT_OUT && (tof_valid || wcnt == WW'(OUT_WAIT_MAX - 1));
  assign emit      = state == ARMED && empty && tmo;
  assign ord       = cal_cnt + 3'd1;
  assign busy      = state != IDLE;
  assign cal_en    = state == CALC;
  assign meas_done = state == DONE;

`ifdef TDC_SEQ_TIMEOUT_EN
  logic [9:0] wd;
  always_ff @(posedge clk)
    wd <= (rst || state == IDLE) ? '0 : wd + {9'd0, wd != 10'h3FF};
  // once tripped, stays tripped for the rest of the measurement
  assign tmo = err[1] || (wd >= range[14:5] && hit_cnt < need);
`else
  logic unused_range;
  assign unused_range = ^range;
  assign tmo = 1'b0;
`endif

  tdc_hit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(hit_t))) u_fifo (
    .clk(clk), .rst(rst), .clr(state == IDLE && arm), .push(push), .pop(pop),
    .din(wr_hit), .dout(rd_hit), .full(full), .empty(empty)
  );

  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = arm ? ARMED : IDLE;
      ARMED:    nxt = !empty ? LOAD : (emit && ord == need) ? DONE : ARMED;
      LOAD:     nxt = CALC;
      CALC:     nxt = bcnt == 3'(CAL_BURST - 1) ? WAIT_OUT : CALC;
      WAIT_OUT: nxt = !fin ? WAIT_OUT : cal_cnt == need ? DONE : !empty ? LOAD : ARMED;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      need        <= '0;
      hit_cnt     <= '0;
      bcnt        <= '0;
      wcnt        <= '0;
      cal_code    <= '0;
      cal_cnt     <= '0;
      cal_counter <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_idx     <= '0;
      err         <= '0;
    end else begin
      res_valid <= 1'b0;
      bcnt      <= state == CALC ? bcnt + 3'd1 : '0;
      wcnt      <= state == WAIT_OUT ? wcnt + WW'(1) : '0;
      if (state == IDLE && arm) begin
        hit_cnt <= '0;
        cal_cnt <= '0;
        err     <= '0;
        need    <= stop_num == 2'd0 ? 3'd2 : {1'b0, stop_num} + 3'd1;
      end
      if (push) hit_cnt <= hit_cnt + 3'd1;
      if (drop) err[0] <= 1'b1;
      if (coll && tmo) err[1] <= 1'b1;
      if (pop || emit) cal_cnt <= ord;
      if (pop) begin
        cal_code    <= rd_hit.code;
        cal_counter <= rd_hit.coarse;
      end
      // ordinal 1 is the start hit and never produces a result
      if ((fin && cal_cnt > 3'd1) || (emit && ord > 3'd1)) begin
        res_valid <= 1'b1;
        res_data  <= (fin && tof_valid) ? tof_data : TOF_INVALID;
        res_idx   <= fin ? 2'(cal_cnt - 3'd1) : cal_cnt[1:0];
      end
    end
endmodule

// File: tb/tb_tdc_seq_ctrl.sv
// tb_tdc_seq_ctrl: directed self-checking bench for tdc_seq_ctrl with a tof_cal reply model.
module tb_tdc_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, arm = 1'b0, hit_valid = 1'b0, tof_valid = 1'b0;
  logic [1:0] stop_num = 2'd0;
  logic [14:0] range = 15'h7FFF, tof_data = 15'h0;
  logic [31:0] hit_code = 32'h0;
  logic [9:0] hit_coarse = 10'h0;
  logic cal_en, res_valid, meas_done, busy;
  logic [31:0] cal_code;
  logic [2:0] cal_cnt;
  logic [9:0] cal_counter;
  logic [14:0] res_data;
  logic [1:0] res_idx, err;

  always #5 clk = ~clk;

  tdc_seq_ctrl dut (
    .clk(clk), .rst(rst), .arm(arm), .stop_num(stop_num), .range(range),
    .hit_valid(hit_valid), .hit_code(hit_code), .hit_coarse(hit_coarse),
    .cal_en(cal_en), .cal_code(cal_code), .cal_cnt(cal_cnt), .cal_counter(cal_counter),
    .tof_valid(tof_valid), .tof_data(tof_data),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .meas_done(meas_done), .busy(busy), .err(err)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0, nb = 0, nr = 0, nd = 0, run = 0, cd = 0, n_badlen = 0, n_unstable = 0;
  int tof_mode = 1;
  logic p_en = 1'b0;
  logic [2:0] p_cnt = 3'd0;
  logic [31:0] p_code = 32'h0;
  logic [9:0] p_coarse = 10'h0;
  int b_cnt[64], b_coarse[64], fall_t[64], r_t[64], r_idx[64], r_data[64];
  logic [31:0] b_code[64];

  // Monitor and tof_cal model: replies two cycles after each burst ends.
  always @(negedge clk) begin
    cyc++;
    tof_valid = 1'b0;
    if (cal_en && !p_en) begin
      if (nb < 64) begin
        b_cnt[nb] = int'(cal_cnt);
        b_code[nb] = cal_code;
        b_coarse[nb] = int'(cal_counter);
      end
      nb++;
      run = 1;
    end else if (cal_en) begin
      run++;
      if (cal_cnt != p_cnt || cal_code != p_code || cal_counter != p_coarse) n_unstable++;
    end
    if (!cal_en && p_en) begin
      if (run != 5) n_badlen++;
      if (nb <= 64) fall_t[nb-1] = cyc;
      if (tof_mode == 1 || (tof_mode == 2 && cal_cnt == 3'd1)) cd = 2;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) tof_valid = 1'b1;
    end
    if (res_valid) begin
      if (nr < 64) begin
        r_t[nr] = cyc;
        r_idx[nr] = int'(res_idx);
        r_data[nr] = int'(res_data);
      end
      nr++;
    end
    if (meas_done) nd++;
    p_en = cal_en;
    p_cnt = cal_cnt;
    p_code = cal_code;
    p_coarse = cal_counter;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] sn);
    stop_num = sn;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic hit(input logic [31:0] code, input logic [9:0] coarse);
    hit_code = code;
    hit_coarse = coarse;
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input int base);
    int k = 0;
    while (nd == base && k < bound) begin
      tick();
      k++;
    end
    check("meas_done_count", 32'(nd - base), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, r0, d0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_cal_en", cal_en, 0);
    check("rst_cal_cnt", cal_cnt, 0);
    check("rst_cal_code", cal_code, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_err", err, 0);
    check("rst_meas_done", meas_done, 0);
    rst = 1'b0;
    tick();

    b0 = nb;
    hit(32'h1234, 10'd7);
    hit(32'h5678, 10'd8);
    repeat (3) tick();
    check("idle_hit_busy", busy, 0);
    check("idle_hit_bursts", 32'(nb - b0), 0);

    // one start + one stop, tof_cal replies every time
    b0 = nb; r0 = nr; d0 = nd;
    tof_mode = 1;
    tof_data = 15'h0124;
    start(2'd1);
    check("t1_busy", busy, 1);
    hit(32'h0000FFFF, 10'd5);
    hit(32'h000FFFFF, 10'd9);
    wait_done(300, d0);
    check("t1_bursts", 32'(nb - b0), 2);
    check("t1_cnt0", 32'(b_cnt[b0]), 1);
    check("t1_code0", b_code[b0], 32'h0000FFFF);
    check("t1_coarse0", 32'(b_coarse[b0]), 5);
    check("t1_cnt1", 32'(b_cnt[b0+1]), 2);
    check("t1_code1", b_code[b0+1], 32'h000FFFFF);
    check("t1_coarse1", 32'(b_coarse[b0+1]), 9);
    check("t1_nres", 32'(nr - r0), 1);
    check("t1_idx", 32'(r_idx[r0]), 1);
    check("t1_data", 32'(r_data[r0]), 32'h0124);
    check("t1_latency", 32'(r_t[r0] - fall_t[b0+1]), 3);
    check("t1_burst_len", 32'(n_badlen), 0);
    check("t1_stable", 32'(n_unstable), 0);
    check("t1_err", err, 0);
    check("t1_idle", busy, 0);

    // three stops back to back; an arm mid-measurement must be ignored
    b0 = nb; r0 = nr; d0 = nd;
    tof_data = 15'h0ABC;
    start(2'd3);
    for (int i = 0; i < 4; i++) hit(32'h1 << (4 * i), 10'(20 + i));
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_done(400, d0);
    check("t2_bursts", 32'(nb - b0), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_cnt%0d", i), 32'(b_cnt[b0+i]), 32'(i + 1));
      check($sformatf("t2_coarse%0d", i), 32'(b_coarse[b0+i]), 32'(20 + i));
    end
    check("t2_nres", 32'(nr - r0), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_idx%0d", i), 32'(r_idx[r0+i]), 32'(i + 1));
      check($sformatf("t2_data%0d", i), 32'(r_data[r0+i]), 32'h0ABC);
    end
    check("t2_err", err, 0);
    check("t2_burst_len", 32'(n_badlen), 0);
    check("t2_stable", 32'(n_unstable), 0);

    // five hits for one stop, no tof replies: overflow and timeouts
    b0 = nb; r0 = nr; d0 = nd;
    tof_mode = 0;
    start(2'd1);
    for (int i = 0; i < 5; i++) hit(32'hF0 + 32'(i), 10'(40 + i));
    wait_done(400, d0);
    check("t3_bursts", 32'(nb - b0), 2);
    check("t3_err", err, 2'b01);
    check("t3_nres", 32'(nr - r0), 1);
    check("t3_data", 32'(r_data[r0]), 32'h7FFF);

    // stop_num 0 acts as 1; start answered, stop never answered
    b0 = nb; r0 = nr; d0 = nd;
    tof_mode = 2;
    tof_data = 15'h0055;
    start(2'd0);
    hit(32'h3, 10'd1);
    hit(32'h7, 10'd2);
    wait_done(300, d0);
    check("t4_bursts", 32'(nb - b0), 2);
    check("t4_nres", 32'(nr - r0), 1);
    check("t4_idx", 32'(r_idx[r0]), 1);
    check("t4_data", 32'(r_data[r0]), 32'h7FFF);
    check("t4_latency", 32'(r_t[r0] - fall_t[b0+1]), 8);
    check("t4_err", err, 0);

    b0 = nb; r0 = nr; d0 = nd;
    tof_mode = 1;
`ifdef TDC_SEQ_TIMEOUT_EN
    range = 15'h0040;
    start(2'd2);
    hit(32'hFF, 10'd3);
    wait_done(300, d0);
    check("wd_bursts", 32'(nb - b0), 1);
    check("wd_err", err, 2'b10);
    check("wd_nres", 32'(nr - r0), 2);
    check("wd_idx0", 32'(r_idx[r0]), 1);
    check("wd_data0", 32'(r_data[r0]), 32'h7FFF);
    check("wd_idx1", 32'(r_idx[r0+1]), 2);
    check("wd_data1", 32'(r_data[r0+1]), 32'h7FFF);
    range = 15'h7FFF;
`else
    start(2'd2);
    hit(32'hFF, 10'd3);
    repeat (100) tick();
    check("nowd_busy", busy, 1);
    check("nowd_done", 32'(nd - d0), 0);
    check("nowd_err", err, 0);
    check("nowd_bursts", 32'(nb - b0), 1);
    check("nowd_nres", 32'(nr - r0), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("nowd_rst_busy", busy, 0);
`endif

    // reset on the third cal_en cycle aborts the measurement silently
    r0 = nr; d0 = nd;
    begin
      int k = 0;
      start(2'd1);
      hit(32'hAA, 10'd11);
      hit(32'hBB, 10'd12);
      while (!(cal_en && run == 3) && k < 100) begin
        tick();
        k++;
      end
    end
    check("t5_third_cal_en", cal_en, 1);
    check("t5_run", 32'(run), 3);
    rst = 1'b1;
    tick();
    check("t5_cal_en", cal_en, 0);
    check("t5_busy", busy, 0);
    check("t5_cal_cnt", cal_cnt, 0);
    check("t5_meas_done", meas_done, 0);
    rst = 1'b0;
    repeat (20) tick();
    check("t5_no_done", 32'(nd - d0), 0);
    check("t5_no_res", 32'(nr - r0), 0);
    check("t5_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
